fetch_pc_unit: RTL and testbench

Fetch stage wrapped around the gshare branch predictor. It holds the PC, drives the predictor lookup and instruction memory requests, and steers the next PC from the predictor's hit/target. It buffers fetched instructions with their prediction metadata in an in-order queue feeding decode. EX-stage redirects flush it.

---
 rtl/fetch_pc_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_pc_unit.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests steered by the predictor,
// and queues returned instructions with their prediction for decode. Optional macro: FETCH_PERF_CNT_EN.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          QUEUE_DEPTH = 4,
   parameter int          PTR_WIDTH   = $clog2(QUEUE_DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] fetchPc,
   input  logic        fetchHit,
   input  logic [31:0] fetchTarget,
   output logic        imemReqValid,
   input  logic        imemReqReady,
   output logic [31:0] imemReqAddr,
   input  logic        imemRspValid,
   input  logic [31:0] imemRspData,
   output logic        decValid,
   input  logic        decReady,
   output logic [31:0] decInstr,
   output logic [31:0] decPc,
   output logic        decPredTaken,
   output logic [31:0] decPredTarget,
   input  logic        exRedirect,
   input  logic [31:0] exRedirectPc,
   output logic [31:0] perfRedirects,
   output logic [31:0] perfFullCycles
);
   localparam logic [PTR_WIDTH:0]   LP_DEPTH   = (PTR_WIDTH+1)'(QUEUE_DEPTH);
   localparam logic [PTR_WIDTH:0]   LP_CNT_ONE = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH-1:0] LP_PTR_ONE = PTR_WIDTH'(1);

   logic [31:0]            r_pc;
   logic [31:0]            r_ent_pc     [QUEUE_DEPTH];
   logic                   r_ent_taken  [QUEUE_DEPTH];
   logic [31:0]            r_ent_target [QUEUE_DEPTH];
   logic [31:0]            r_ent_instr  [QUEUE_DEPTH];
   logic [QUEUE_DEPTH-1:0] r_ent_filled;
   logic [PTR_WIDTH-1:0]   r_head;
   logic [PTR_WIDTH-1:0]   r_tail;
   logic [PTR_WIDTH-1:0]   r_fill;
   logic [PTR_WIDTH:0]     r_count;
   logic [PTR_WIDTH:0]     r_pending;
   logic [PTR_WIDTH:0]     r_drop;

   logic                   w_req_fire;
   logic                   w_pop;
   logic                   w_rsp_live;
   logic                   w_rsp_drop;
   logic                   w_rsp_fill;
   logic [31:0]            w_next_pc;
   logic [PTR_WIDTH:0]     w_redirect_drop;

   // Handshakes: a transfer happens on a cycle where valid && ready; valid never depends on ready.
   always_comb begin
      fetchPc         = r_pc;
      imemReqAddr     = r_pc;
      imemReqValid    = !rst && !exRedirect && (r_count < LP_DEPTH);
      decValid        = r_ent_filled[r_head] && (r_count != '0);
      decPc           = r_ent_pc[r_head];
      decInstr        = r_ent_instr[r_head];
      decPredTaken    = r_ent_taken[r_head];
      decPredTarget   = r_ent_target[r_head];
      w_req_fire      = imemReqValid && imemReqReady;
      w_pop           = decValid && decReady;
      w_rsp_live      = imemRspValid && ((r_pending != '0) || (r_drop != '0));
      w_rsp_drop      = w_rsp_live && (r_drop != '0);
      w_rsp_fill      = w_rsp_live && (r_drop == '0) && !exRedirect && !rst;
      w_next_pc       = fetchHit ? fetchTarget : r_pc + 32'd4;
      // Every in-flight response becomes stale; one arriving right now is already consumed.
      w_redirect_drop = r_pending + r_drop - (w_rsp_live ? LP_CNT_ONE : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_head       <= '0;
         r_tail       <= '0;
         r_fill       <= '0;
         r_count      <= '0;
         r_pending    <= '0;
         r_drop       <= '0;
         r_ent_filled <= '0;
      end else if (exRedirect) begin
         r_pc         <= exRedirectPc;
         r_head       <= '0;
         r_tail       <= '0;
         r_fill       <= '0;
         r_count      <= '0;
         r_pending    <= '0;
         r_drop       <= w_redirect_drop;
         r_ent_filled <= '0;
      end else begin
         if (w_req_fire) begin
            r_pc                 <= w_next_pc;
            r_tail               <= r_tail + LP_PTR_ONE;
            r_ent_filled[r_tail] <= 1'b0;
         end
         if (w_rsp_drop) begin
            r_drop <= r_drop - LP_CNT_ONE;
         end
         if (w_rsp_fill) begin
            r_ent_filled[r_fill] <= 1'b1;
            r_fill               <= r_fill + LP_PTR_ONE;
         end
         if (w_pop) begin
            r_head <= r_head + LP_PTR_ONE;
         end
         case ({w_req_fire, w_pop})
            2'b10:   r_count <= r_count + LP_CNT_ONE;
            2'b01:   r_count <= r_count - LP_CNT_ONE;
            default: ;
         endcase
         case ({w_req_fire, w_rsp_fill})
            2'b10:   r_pending <= r_pending + LP_CNT_ONE;
            2'b01:   r_pending <= r_pending - LP_CNT_ONE;
            default: ;
         endcase
      end
   end

   // Payload storage needs no reset; the filled flags and count gate visibility.
   always_ff @(posedge clk) begin
      if (w_req_fire) begin
         r_ent_pc[r_tail]     <= r_pc;
         r_ent_taken[r_tail]  <= fetchHit;
         r_ent_target[r_tail] <= fetchTarget;
      end
      if (w_rsp_fill) begin
         r_ent_instr[r_fill] <= imemRspData;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_redirects;
   logic [31:0] r_perf_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_redirects <= '0;
         r_perf_full      <= '0;
      end else begin
         if (exRedirect && (r_perf_redirects != 32'hFFFF_FFFF)) begin
            r_perf_redirects <= r_perf_redirects + 32'd1;
         end
         if ((r_count == LP_DEPTH) && (r_perf_full != 32'hFFFF_FFFF)) begin
            r_perf_full <= r_perf_full + 32'd1;
         end
      end
   end

   assign perfRedirects  = r_perf_redirects;
   assign perfFullCycles = r_perf_full;
`else
   assign perfRedirects  = '0;
   assign perfFullCycles = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus a randomized run checked against
// a queue-level model of the fetch queue and an in-order, epoch-tagged memory.
module tb_fetch_pc_unit;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [31:0] fetchPc;
   logic        fetchHit;
   logic [31:0] fetchTarget;
   logic        imemReqValid;
   logic        imemReqReady;
   logic [31:0] imemReqAddr;
   logic        imemRspValid;
   logic [31:0] imemRspData;
   logic        decValid;
   logic        decReady;
   logic [31:0] decInstr;
   logic [31:0] decPc;
   logic        decPredTaken;
   logic [31:0] decPredTarget;
   logic        exRedirect;
   logic [31:0] exRedirectPc;
   logic [31:0] perfRedirects;
   logic [31:0] perfFullCycles;

   fetch_pc_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget),
      .imemReqValid(imemReqValid), .imemReqReady(imemReqReady), .imemReqAddr(imemReqAddr),
      .imemRspValid(imemRspValid), .imemRspData(imemRspData),
      .decValid(decValid), .decReady(decReady), .decInstr(decInstr), .decPc(decPc),
      .decPredTaken(decPredTaken), .decPredTarget(decPredTarget),
      .exRedirect(exRedirect), .exRedirectPc(exRedirectPc),
      .perfRedirects(perfRedirects), .perfFullCycles(perfFullCycles)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Per-cycle drive knobs
   logic        drv_rst, drv_req_ready, drv_dec_ready, drv_hit, drv_redir, drv_spurious;
   logic [31:0] drv_target, drv_redir_pc;
   int          drv_lat_min, drv_lat_max;

   // Reference model: fetch queue entries of the current epoch, plus the memory pipe
   logic [31:0] m_pc;
   int          m_epoch;
   logic [31:0] m_perf_redir, m_perf_full;
   logic [31:0] q_pc[$];
   logic        q_taken[$];
   logic [31:0] q_target[$];
   logic        q_filled[$];
   logic [31:0] q_instr[$];
   logic [31:0] mem_addr[$];
   int          mem_epoch[$];
   int          mem_due[$];

   // Snapshots taken just before each rising edge
   logic [31:0] s_fetch_pc, s_req_addr, s_dec_pc, s_dec_instr, s_dec_target, s_perf_redir, s_perf_full;
   logic        s_req_valid, s_dec_valid, s_dec_taken;
   logic [31:0] e_pc, e_dec_pc, e_dec_instr, e_dec_target, e_perf_redir, e_perf_full;
   logic        e_req_valid, e_dec_valid, e_dec_taken;

   // Observed transfers
   logic [31:0] obs_req_q[$];
   logic [31:0] obs_dec_pc_q[$];
   logic [31:0] obs_dec_instr_q[$];
   logic        obs_dec_taken_q[$];
   logic [31:0] obs_dec_target_q[$];
   logic [31:0] exp_q[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
   endfunction

   task automatic clear_obs();
      obs_req_q.delete();
      obs_dec_pc_q.delete();
      obs_dec_instr_q.delete();
      obs_dec_taken_q.delete();
      obs_dec_target_q.delete();
   endtask

   task automatic set_idle();
      drv_rst = 1'b0; drv_req_ready = 1'b0; drv_dec_ready = 1'b0; drv_hit = 1'b0;
      drv_redir = 1'b0; drv_spurious = 1'b0; drv_target = 32'h0; drv_redir_pc = 32'h0;
      drv_lat_min = 1; drv_lat_max = 1;
   endtask

   // Driver: one clock cycle starting at a falling edge
   task automatic step();
      logic        rsp, accept, do_pop, found;
      logic [31:0] rdata;
      int          due;
      rsp   = 1'b0;
      rdata = 32'hDEAD_BEEF;
      if (!drv_rst && mem_due.size() > 0 && mem_due[0] <= cyc) begin
         rsp   = 1'b1;
         rdata = mem_word(mem_addr[0]);
      end else if (!drv_rst && drv_spurious && mem_due.size() == 0) begin
         rsp = 1'b1;
      end
      rst          = drv_rst;
      imemReqReady = drv_req_ready;
      fetchHit     = drv_hit;
      fetchTarget  = drv_target;
      imemRspValid = rsp;
      imemRspData  = rdata;
      decReady     = drv_dec_ready;
      exRedirect   = drv_redir;
      exRedirectPc = drv_redir_pc;
      #1;
      s_fetch_pc   = fetchPc;      s_req_valid  = imemReqValid;  s_req_addr  = imemReqAddr;
      s_dec_valid  = decValid;     s_dec_pc     = decPc;         s_dec_instr = decInstr;
      s_dec_taken  = decPredTaken; s_dec_target = decPredTarget;
      s_perf_redir = perfRedirects; s_perf_full = perfFullCycles;
      e_pc        = m_pc;
      e_req_valid = !drv_rst && !drv_redir && (q_pc.size() < DEPTH);
      e_dec_valid = (q_pc.size() > 0) && q_filled[0];
      e_dec_pc     = e_dec_valid ? q_pc[0]     : 32'h0;
      e_dec_instr  = e_dec_valid ? q_instr[0]  : 32'h0;
      e_dec_taken  = e_dec_valid ? q_taken[0]  : 1'b0;
      e_dec_target = e_dec_valid ? q_target[0] : 32'h0;
`ifdef FETCH_PERF_CNT_EN
      e_perf_redir = m_perf_redir;
      e_perf_full  = m_perf_full;
`else
      e_perf_redir = 32'h0;
      e_perf_full  = 32'h0;
`endif
      if (s_req_valid && drv_req_ready) obs_req_q.push_back(s_req_addr);
      if (s_dec_valid && drv_dec_ready) begin
         obs_dec_pc_q.push_back(s_dec_pc);
         obs_dec_instr_q.push_back(s_dec_instr);
         obs_dec_taken_q.push_back(s_dec_taken);
         obs_dec_target_q.push_back(s_dec_target);
      end
      accept = e_req_valid && drv_req_ready;
      do_pop = e_dec_valid && drv_dec_ready;
      if (drv_rst) begin
         m_pc = RESET_PC; m_perf_redir = 32'h0; m_perf_full = 32'h0;
         q_pc.delete(); q_taken.delete(); q_target.delete(); q_filled.delete(); q_instr.delete();
         mem_addr.delete(); mem_epoch.delete(); mem_due.delete();
      end else begin
         if (drv_redir && m_perf_redir != 32'hFFFF_FFFF) m_perf_redir = m_perf_redir + 32'd1;
         if (q_pc.size() == DEPTH && m_perf_full != 32'hFFFF_FFFF) m_perf_full = m_perf_full + 32'd1;
         if (rsp && mem_due.size() > 0) begin
            if (mem_epoch[0] == m_epoch) begin
               found = 1'b0;
               for (int i = 0; i < q_pc.size(); i++) begin
                  if (!found && !q_filled[i]) begin
                     q_filled[i] = 1'b1;
                     q_instr[i]  = rdata;
                     found       = 1'b1;
                  end
               end
            end
            void'(mem_addr.pop_front()); void'(mem_epoch.pop_front()); void'(mem_due.pop_front());
         end
         if (drv_redir) begin
            q_pc.delete(); q_taken.delete(); q_target.delete(); q_filled.delete(); q_instr.delete();
            m_epoch = m_epoch + 1;
            m_pc    = drv_redir_pc;
         end else begin
            if (do_pop) begin
               void'(q_pc.pop_front()); void'(q_taken.pop_front()); void'(q_target.pop_front());
               void'(q_filled.pop_front()); void'(q_instr.pop_front());
            end
            if (accept) begin
               q_pc.push_back(m_pc); q_taken.push_back(drv_hit); q_target.push_back(drv_target);
               q_filled.push_back(1'b0); q_instr.push_back(32'h0);
               due = cyc + $urandom_range(drv_lat_min, drv_lat_max);
               if (mem_due.size() > 0 && due <= mem_due[$]) due = mem_due[$] + 1;
               mem_addr.push_back(m_pc); mem_epoch.push_back(m_epoch); mem_due.push_back(due);
               m_pc = drv_hit ? drv_target : m_pc + 32'd4;
            end
         end
      end
      @(posedge clk);
      cyc = cyc + 1;
      @(negedge clk);
   endtask

   task automatic do_reset();
      set_idle();
      drv_rst = 1'b1;
      step();
      step();
      drv_rst = 1'b0;
      clear_obs();
   endtask

   task automatic test_reset();
      set_idle();
      drv_rst = 1'b1;
      step();
      step();
      total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid: got %b want 0", s_req_valid); end
      drv_rst = 1'b0;
      step();
      total++; if (s_fetch_pc !== RESET_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", s_fetch_pc, RESET_PC); end
      total++; if (s_dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid: got %b want 0", s_dec_valid); end
      total++; if (s_req_valid !== 1'b1) begin bad++; $display("FAIL reset_req_after: got %b want 1", s_req_valid); end
      total++; if (s_perf_redir !== 32'h0 || s_perf_full !== 32'h0) begin
         bad++; $display("FAIL reset_perf: got %h/%h want 0/0", s_perf_redir, s_perf_full);
      end
      drv_spurious = 1'b1;
      step();
      drv_spurious = 1'b0;
      step();
      total++; if (s_dec_valid !== 1'b0) begin bad++; $display("FAIL spurious_rsp: dec_valid got %b want 0", s_dec_valid); end
   endtask

   task automatic test_sequential();
      do_reset();
      drv_req_ready = 1'b1; drv_dec_ready = 1'b1;
      repeat (7) step();
      exp_q = '{32'h0, 32'h4, 32'h8};
      total++; if (obs_dec_pc_q.size() < 3) begin bad++; $display("FAIL seq_dec_count: got %0d want >=3", obs_dec_pc_q.size()); end
      for (int i = 0; i < 3; i++) begin
         total++; if (obs_req_q[i] !== exp_q[i]) begin bad++; $display("FAIL seq_req_addr[%0d]: got %h want %h", i, obs_req_q[i], exp_q[i]); end
         total++; if (obs_dec_pc_q[i] !== exp_q[i]) begin bad++; $display("FAIL seq_dec_pc[%0d]: got %h want %h", i, obs_dec_pc_q[i], exp_q[i]); end
         total++; if (obs_dec_instr_q[i] !== mem_word(exp_q[i])) begin
            bad++; $display("FAIL seq_dec_instr[%0d]: got %h want %h", i, obs_dec_instr_q[i], mem_word(exp_q[i]));
         end
      end
   endtask

   task automatic test_predict();
      do_reset();
      drv_req_ready = 1'b1; drv_dec_ready = 1'b1; drv_target = 32'h100;
      for (int i = 0; i < 8; i++) begin
         drv_hit = (m_pc == 32'h8);
         step();
      end
      drv_hit = 1'b0;
      total++; if (obs_req_q[3] !== 32'h100) begin bad++; $display("FAIL pred_req_after_hit: got %h want 00000100", obs_req_q[3]); end
      total++; if (obs_req_q[4] !== 32'h104) begin bad++; $display("FAIL pred_req_next: got %h want 00000104", obs_req_q[4]); end
      total++; if (obs_dec_pc_q[2] !== 32'h8 || obs_dec_taken_q[2] !== 1'b1 || obs_dec_target_q[2] !== 32'h100) begin
         bad++; $display("FAIL pred_entry: got pc=%h taken=%b target=%h want 8/1/100",
                         obs_dec_pc_q[2], obs_dec_taken_q[2], obs_dec_target_q[2]);
      end
      total++; if (obs_dec_taken_q[1] !== 1'b0) begin bad++; $display("FAIL pred_not_taken: got %b want 0", obs_dec_taken_q[1]); end
      total++; if (obs_dec_pc_q[3] !== 32'h100 || obs_dec_instr_q[3] !== mem_word(32'h100)) begin
         bad++; $display("FAIL pred_target_fetch: got pc=%h instr=%h want 100/%h", obs_dec_pc_q[3], obs_dec_instr_q[3], mem_word(32'h100));
      end
   endtask

   task automatic test_full();
      do_reset();
      drv_req_ready = 1'b1; drv_dec_ready = 1'b0;
      repeat (8) step();
      total++; if (obs_req_q.size() != 4) begin bad++; $display("FAIL full_req_count: got %0d want 4", obs_req_q.size()); end
      total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL full_req_valid: got %b want 0", s_req_valid); end
      total++; if (s_dec_valid !== 1'b1) begin bad++; $display("FAIL full_dec_valid: got %b want 1", s_dec_valid); end
      drv_dec_ready = 1'b1;
      step();
      drv_dec_ready = 1'b0;
      repeat (4) step();
      total++; if (obs_req_q.size() != 5) begin bad++; $display("FAIL full_refill_count: got %0d want 5", obs_req_q.size()); end
      total++; if (obs_req_q[4] !== 32'h10) begin bad++; $display("FAIL full_refill_addr: got %h want 00000010", obs_req_q[4]); end
      total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL full_again: got %b want 0", s_req_valid); end
   endtask

   task automatic test_redirect();
      do_reset();
      drv_req_ready = 1'b1; drv_dec_ready = 1'b1; drv_lat_min = 4; drv_lat_max = 4;
      repeat (3) step();
      drv_redir = 1'b1; drv_redir_pc = 32'h200;
      step();
      total++; if (s_req_valid !== 1'b0) begin bad++; $display("FAIL redir_no_req: got %b want 0", s_req_valid); end
      drv_redir = 1'b0; drv_lat_min = 1; drv_lat_max = 1;
      clear_obs();
      repeat (10) step();
      total++; if (obs_req_q[0] !== 32'h200) begin bad++; $display("FAIL redir_first_req: got %h want 00000200", obs_req_q[0]); end
      total++; if (obs_dec_pc_q.size() < 2) begin bad++; $display("FAIL redir_dec_count: got %0d want >=2", obs_dec_pc_q.size()); end
      for (int i = 0; i < 2; i++) begin
         total++; if (obs_dec_pc_q[i] !== 32'h200 + 32'(4 * i) || obs_dec_instr_q[i] !== mem_word(32'h200 + 32'(4 * i))) begin
            bad++; $display("FAIL redir_dec[%0d]: got pc=%h instr=%h want %h/%h", i, obs_dec_pc_q[i], obs_dec_instr_q[i],
                            32'h200 + 32'(4 * i), mem_word(32'h200 + 32'(4 * i)));
         end
      end
   endtask

   task automatic test_redirect_rsp();
      do_reset();
      drv_req_ready = 1'b1; drv_dec_ready = 1'b1; drv_lat_min = 2; drv_lat_max = 2;
      repeat (2) step();
      drv_redir = 1'b1; drv_redir_pc = 32'h500;
      step();
      drv_redir = 1'b0; drv_lat_min = 1; drv_lat_max = 1;
      clear_obs();
      repeat (8) step();
      total++; if (obs_req_q[0] !== 32'h500) begin bad++; $display("FAIL rrsp_first_req: got %h want 00000500", obs_req_q[0]); end
      total++; if (obs_dec_pc_q.size() < 2) begin bad++; $display("FAIL rrsp_dec_count: got %0d want >=2", obs_dec_pc_q.size()); end
      for (int i = 0; i < 2; i++) begin
         total++; if (obs_dec_pc_q[i] !== 32'h500 + 32'(4 * i) || obs_dec_instr_q[i] !== mem_word(32'h500 + 32'(4 * i))) begin
            bad++; $display("FAIL rrsp_dec[%0d]: got pc=%h instr=%h want %h/%h", i, obs_dec_pc_q[i], obs_dec_instr_q[i],
                            32'h500 + 32'(4 * i), mem_word(32'h500 + 32'(4 * i)));
         end
      end
   endtask

   task automatic test_back_to_back_perf();
      logic [31:0] want_redir, want_full;
`ifdef FETCH_PERF_CNT_EN
      want_redir = 32'd2; want_full = 32'd5;
`else
      want_redir = 32'd0; want_full = 32'd0;
`endif
      do_reset();
      drv_redir = 1'b1; drv_redir_pc = 32'h300;
      step();
      drv_redir_pc = 32'h400;
      step();
      drv_redir = 1'b0; drv_req_ready = 1'b1;
      repeat (9) step();
      total++; if (obs_req_q[0] !== 32'h400) begin bad++; $display("FAIL b2b_later_wins: got %h want 00000400", obs_req_q[0]); end
      total++; if (obs_req_q.size() != 4) begin bad++; $display("FAIL b2b_req_count: got %0d want 4", obs_req_q.size()); end
      step();
      total++; if (s_perf_redir !== want_redir) begin bad++; $display("FAIL perf_redirects: got %0d want %0d", s_perf_redir, want_redir); end
      total++; if (s_perf_full !== want_full) begin bad++; $display("FAIL perf_full_cycles: got %0d want %0d", s_perf_full, want_full); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 800; n++) begin
         drv_rst       = ($urandom_range(0, 199) == 0);
         drv_req_ready = ($urandom_range(0, 9) < 7);
         drv_dec_ready = ($urandom_range(0, 9) < 6);
         drv_hit       = ($urandom_range(0, 4) == 0);
         drv_target    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
         drv_redir     = ($urandom_range(0, 19) == 0) || (drv_redir && ($urandom_range(0, 1) == 0));
         drv_redir_pc  = $urandom & 32'h0000_FFFC;
         drv_spurious  = ($urandom_range(0, 9) == 0);
         drv_lat_min   = 1;
         drv_lat_max   = 3;
         step();
         total++; if (s_fetch_pc !== e_pc || s_req_addr !== e_pc) begin
            bad++; $display("FAIL rnd_pc @%0d: got %h/%h want %h", cyc, s_fetch_pc, s_req_addr, e_pc);
         end
         total++; if (s_req_valid !== e_req_valid) begin bad++; $display("FAIL rnd_req_valid @%0d: got %b want %b", cyc, s_req_valid, e_req_valid); end
         total++; if (s_dec_valid !== e_dec_valid) begin bad++; $display("FAIL rnd_dec_valid @%0d: got %b want %b", cyc, s_dec_valid, e_dec_valid); end
         if (e_dec_valid) begin
            total++;
            if (s_dec_pc !== e_dec_pc || s_dec_instr !== e_dec_instr || s_dec_taken !== e_dec_taken || s_dec_target !== e_dec_target) begin
               bad++; $display("FAIL rnd_dec_entry @%0d: got %h/%h/%b/%h want %h/%h/%b/%h", cyc, s_dec_pc, s_dec_instr, s_dec_taken,
                               s_dec_target, e_dec_pc, e_dec_instr, e_dec_taken, e_dec_target);
            end
         end
         total++; if (s_perf_redir !== e_perf_redir || s_perf_full !== e_perf_full) begin
            bad++; $display("FAIL rnd_perf @%0d: got %0d/%0d want %0d/%0d", cyc, s_perf_redir, s_perf_full, e_perf_redir, e_perf_full);
         end
      end
   endtask

   initial begin
      rst = 1'b1; imemReqReady = 1'b0; fetchHit = 1'b0; fetchTarget = 32'h0; imemRspValid = 1'b0;
      imemRspData = 32'h0; decReady = 1'b0; exRedirect = 1'b0; exRedirectPc = 32'h0;
      m_pc = RESET_PC; m_epoch = 0; m_perf_redir = 32'h0; m_perf_full = 32'h0;
      set_idle();
      @(negedge clk);
      test_reset();
      test_sequential();
      test_predict();
      test_full();
      test_redirect();
      test_redirect_rsp();
      test_back_to_back_perf();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
